// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, field positions, instruction classes.
// The control unit decodes against the same definitions the encoder uses here.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam int unsigned OP_LSB     = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_LSB = 0;

  typedef enum logic [2:0] {
    ClsR       = 3'd0,
    ClsLw      = 3'd1,
    ClsSw      = 3'd2,
    ClsBeq     = 3'd3,
    ClsJ       = 3'd4,
    ClsAddi    = 3'd5,
    ClsSlti    = 3'd6,
    ClsIllegal = 3'd7
  } instr_class_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;

  function automatic logic [31:0] encode_instr(instr_class_e cls, instr_fields_t f);
    logic [31:0] w;
    logic [5:0]  op;
    w = '0;
    case (cls)
      ClsLw:   op = OP_LW;
      ClsSw:   op = OP_SW;
      ClsBeq:  op = OP_BEQ;
      ClsJ:    op = OP_J;
      ClsAddi: op = OP_ADDI;
      ClsSlti: op = OP_SLTI;
      default: op = OP_RTYPE;
    endcase
    w[OP_LSB +: 6] = op;
    if (cls == ClsJ) begin
      w[TARGET_LSB +: 26] = f.target;
    end else begin
      w[RS_LSB +: 5] = f.rs;
      w[RT_LSB +: 5] = f.rt;
      if (cls == ClsR) begin
        w[RD_LSB +: 5]    = f.rd;
        w[SHAMT_LSB +: 5] = f.shamt;
        w[FUNCT_LSB +: 6] = f.funct;
      end else begin
        w[IMM_LSB +: 16] = f.imm;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle handshake between a program source and the instruction encoder.
interface instr_encoder_if;
  import mips_pkg::*;

  logic          in_valid;
  logic          in_ready;
  instr_class_e  in_class;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_shamt;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;

  modport master (
    output in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    output in_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; clr_i empties it and wins over push/pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i && !full_o) wptr_d = wptr_q + PtrOne;
      if (pop_i && !empty_o) rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clr_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes MIPS field bundles, buffers them and writes them to imem
// at consecutive word addresses, one per cycle.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              finish_i,
  instr_encoder_if.slave    in_bus,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              done_o,
  output logic              err_illegal_o,
  output logic              err_overflow_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [CntW-1:0]   CntOne   = 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d, addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                err_ill_q, err_ill_d, err_ovf_q, err_ovf_d;

  logic                fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [31:0]         fifo_wdata, fifo_rdata;
  logic [CntW-1:0]     fifo_count;

  instr_class_e        cls;
  instr_fields_t       fields;
  logic                in_ready, accept, cls_illegal, end_of_mem;

  assign cls    = in_bus.in_class;
  assign fields = '{rs: in_bus.in_rs, rt: in_bus.in_rt, rd: in_bus.in_rd,
                    shamt: in_bus.in_shamt, funct: in_bus.in_funct,
                    imm: in_bus.in_imm, target: in_bus.in_target};
  assign fifo_wdata = encode_instr(cls, fields);

  // No push-while-full bypass: readiness ignores a same-cycle pop.
  assign in_ready        = (state_q == StRun) && !fifo_full;
  assign in_bus.in_ready = in_ready;
  assign accept          = in_bus.in_valid && in_ready;
  assign cls_illegal     = (cls == ClsIllegal);
  assign fifo_push       = accept && !cls_illegal;
  assign fifo_pop        = ((state_q == StRun) || (state_q == StDrain)) && !fifo_empty;
  assign end_of_mem      = fifo_pop && (cnt_q == '1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    err_ill_d = err_ill_q;
    err_ovf_d = err_ovf_q;
    fifo_clr  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StRun;
          cnt_d     = BaseAddr;
          err_ill_d = 1'b0;
          err_ovf_d = 1'b0;
        end
      end
      StRun: begin
        if (finish_i) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
    endcase

    if (accept && cls_illegal) err_ill_d = 1'b1;

    if (fifo_pop) begin
      we_d    = 1'b1;
      addr_d  = cnt_q;
      wdata_d = fifo_rdata;
      cnt_d   = cnt_q + ADDR_W'(1);
    end

    // Last address written: anything still queued or arriving now is dropped.
    if (end_of_mem) begin
      state_d  = StDone;
      fifo_clr = 1'b1;
      if ((fifo_count > CntOne) || accept) err_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= BaseAddr;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      err_ill_q <= err_ill_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign done_o         = (state_q == StDone);
  assign err_illegal_o  = err_ill_q;
  assign err_overflow_o = err_ovf_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default instance plus a tiny-memory instance
// (ADDR_W=3, BASE_ADDR=6) for the end-of-memory case.
module tb_instr_encoder;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, finish, start_s, finish_s;
  instr_encoder_if bus();
  instr_encoder_if bus_s();

  logic        imem_we, done, err_ill, err_ovf;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_we_s, done_s, err_ill_s, err_ovf_s;
  logic [2:0]  imem_addr_s;
  logic [31:0] imem_wdata_s;

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .finish_i(finish), .in_bus(bus),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .done_o(done), .err_illegal_o(err_ill), .err_overflow_o(err_ovf)
  );

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(3), .BASE_ADDR(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(start_s), .finish_i(finish_s), .in_bus(bus_s),
    .imem_we_o(imem_we_s), .imem_addr_o(imem_addr_s), .imem_wdata_o(imem_wdata_s),
    .done_o(done_s), .err_illegal_o(err_ill_s), .err_overflow_o(err_ovf_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  logic [2:0]  wa_s[$];
  logic [31:0] wd_s[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      wc_q.push_back(cyc);
    end
    if (imem_we_s === 1'b1) begin
      wa_s.push_back(imem_addr_s);
      wd_s.push_back(imem_wdata_s);
    end
  end

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); wa_s.delete(); wd_s.delete();
  endtask

  task automatic drive(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] tgt);
    bus.in_valid = 1'b1; bus.in_class = instr_class_e'(c);
    bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd; bus.in_shamt = sh;
    bus.in_funct = fn; bus.in_imm = imm; bus.in_target = tgt;
  endtask

  // Holds the bundle until accepted; acc is the cycle stamp of the accepting edge.
  task automatic send(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, output int acc);
    int n = 0;
    acc = -1;
    drive(c, rs, rt, rd, sh, fn, imm, tgt);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n == 20) begin
      n_err++; $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end else begin
      @(posedge clk); #1; acc = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; @(posedge clk); #1; finish = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k = 0;
    while (wa_q.size() < n && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (wa_q.size() < n) begin
      n_err++; $display("FAIL write_timeout: got %0d writes, required %0d", wa_q.size(), n);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL done_timeout: done=%b, required 1", done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; start_s = 1'b0; finish_s = 1'b0;
    bus.in_valid = 1'b0; bus_s.in_valid = 1'b0; bus_s.in_class = ClsAddi;
    bus_s.in_rs = '0; bus_s.in_rt = '0; bus_s.in_rd = '0; bus_s.in_shamt = '0;
    bus_s.in_funct = '0; bus_s.in_imm = '0; bus_s.in_target = '0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({imem_we, done, err_ill, err_ovf, bus.in_ready} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: we/done/ill/ovf/rdy=%b, required 00000",
                        {imem_we, done, err_ill, err_ovf, bus.in_ready});
    end
    n_cmp++;
    if (imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_bus: addr=%h data=%h, required 00/00000000", imem_addr,
                        imem_wdata);
    end
    n_cmp++;
    if ({imem_we_s, done_s, err_ovf_s, bus_s.in_ready} !== 4'b0) begin
      n_err++; $display("FAIL reset_small: flags=%b, required 0000",
                        {imem_we_s, done_s, err_ovf_s, bus_s.in_ready});
    end
  endtask

  task automatic test_single();
    int acc;
    start = 1'b1; finish = 1'b1; @(posedge clk); #1; start = 1'b0; finish = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL start_wins: rdy=%b done=%b, required 1/0", bus.in_ready, done);
    end
    clear_q();
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, acc);
    wait_writes(1);
    n_cmp++;
    if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'h00221820) begin
      n_err++; $display("FAIL rtype_word: addr=%h data=%h, required 00/00221820", wa_q[0],
                        wd_q[0]);
    end
    n_cmp++;
    if (wc_q[0] !== acc + 1) begin
      n_err++; $display("FAIL rtype_latency: write cycle %0d, required %0d", wc_q[0], acc + 1);
    end
    pulse_finish();
    wait_done();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL done_ready: in_ready=%b, required 0", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    logic [31:0] exp_w [3] = '{32'h8FA80004, 32'h1022FFFF, 32'h08000010};
    pulse_start();
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL restart_done: done=%b, required 0", done); end
    clear_q();
    send(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0, a0);
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0, a1);
    send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, a2);
    n_cmp++;
    if (a1 !== a0 + 1 || a2 !== a0 + 2) begin
      n_err++; $display("FAIL b2b_accept: accepts at %0d %0d %0d, required consecutive", a0, a1,
                        a2);
    end
    pulse_finish();
    wait_done();
    n_cmp++;
    if (wa_q.size() !== 3) begin
      n_err++; $display("FAIL b2b_count: %0d writes, required 3", wa_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wa_q[i] !== 8'(i) || wd_q[i] !== exp_w[i] || wc_q[i] !== a0 + 1 + i) begin
        n_err++; $display("FAIL b2b_word%0d: addr=%h data=%h cyc=%0d, required %h/%h/%0d", i,
                          wa_q[i], wd_q[i], wc_q[i], 8'(i), exp_w[i], a0 + 1 + i);
      end
    end
  endtask

  task automatic test_stream();
    int acc [6];
    pulse_start();
    clear_q();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) start = 1'b1;
      send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0040 + 16'(i), 26'h0, acc[i]);
      start = 1'b0;
    end
    n_cmp++;
    if (acc[5] !== acc[0] + 5) begin
      n_err++; $display("FAIL stream_stall: 6 accepts spanned %0d edges, required 5",
                        acc[5] - acc[0]);
    end
    pulse_finish();
    wait_done();
    n_cmp++;
    if (wa_q.size() !== 6) begin
      n_err++; $display("FAIL stream_count: %0d writes, required 6", wa_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (wa_q[i] !== 8'(i) || wd_q[i] !== 32'h20000040 + 32'(i)) begin
        n_err++; $display("FAIL stream_word%0d: addr=%h data=%h, required %h/%h", i, wa_q[i],
                          wd_q[i], 8'(i), 32'h20000040 + 32'(i));
      end
    end
  endtask

  task automatic test_illegal();
    int acc;
    pulse_start();
    clear_q();
    send(3'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, acc);
    send(3'd7, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hBEEF, 26'h0, acc);
    send(3'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 26'h0, acc);
    pulse_finish();
    wait_done();
    n_cmp++;
    if (err_ill !== 1'b1 || wa_q.size() !== 2) begin
      n_err++; $display("FAIL illegal_flag: err_illegal=%b writes=%0d, required 1/2", err_ill,
                        wa_q.size());
    end
    n_cmp++;
    if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'h20220005 || wa_q[1] !== 8'd1 ||
        wd_q[1] !== 32'h20641234) begin
      n_err++; $display("FAIL illegal_words: %h:%h %h:%h, required 00:20220005 01:20641234",
                        wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
    end
    pulse_start();
    n_cmp++;
    if (err_ill !== 1'b0) begin
      n_err++; $display("FAIL illegal_clear: err_illegal=%b after start, required 0", err_ill);
    end
    pulse_finish();
    wait_done();
  endtask

  task automatic test_overflow();
    int   k = 0;
    logic rdy;
    start_s = 1'b1; @(posedge clk); #1; start_s = 1'b0;
    clear_q();
    bus_s.in_valid = 1'b1; bus_s.in_class = ClsAddi; bus_s.in_imm = 16'h0100;
    for (int c = 0; c < 8; c++) begin
      rdy = bus_s.in_ready;
      @(posedge clk); #1;
      if (rdy && k < 4) k++;
      if (k < 4) bus_s.in_imm = 16'h0100 + 16'(k);
      else bus_s.in_valid = 1'b0;
    end
    bus_s.in_valid = 1'b0;
    n_cmp++;
    if (k !== 3) begin n_err++; $display("FAIL ovf_accepts: %0d accepted, required 3", k); end
    n_cmp++;
    if (wa_s.size() !== 2) begin
      n_err++; $display("FAIL ovf_count: %0d writes, required 2", wa_s.size());
    end
    n_cmp++;
    if (wa_s[0] !== 3'd6 || wd_s[0] !== 32'h20000100 || wa_s[1] !== 3'd7 ||
        wd_s[1] !== 32'h20000101) begin
      n_err++; $display("FAIL ovf_words: %h:%h %h:%h, required 6:20000100 7:20000101", wa_s[0],
                        wd_s[0], wa_s[1], wd_s[1]);
    end
    n_cmp++;
    if ({done_s, err_ovf_s, bus_s.in_ready, err_ovf} !== 4'b1100) begin
      n_err++; $display("FAIL ovf_state: done/ovf/rdy/main_ovf=%b, required 1100",
                        {done_s, err_ovf_s, bus_s.in_ready, err_ovf});
    end
  endtask

  task automatic test_reset_mid_drain();
    int acc;
    pulse_start();
    clear_q();
    drive(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
    @(posedge clk); #1;
    drive(3'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0);
    @(posedge clk); #1;
    drive(3'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 26'h0);
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0; bus.in_valid = 1'b0;
    n_cmp++;
    if ({imem_we, err_ill, bus.in_ready} !== 3'b110) begin
      n_err++; $display("FAIL pre_reset: we/ill/rdy=%b, required 110",
                        {imem_we, err_ill, bus.in_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_we, done, err_ill, err_ovf, bus.in_ready, done_s, err_ovf_s} !== 7'b0) begin
      n_err++; $display("FAIL async_reset: flags=%b, required 0000000",
                        {imem_we, done, err_ill, err_ovf, bus.in_ready, done_s, err_ovf_s});
    end
    n_cmp++;
    if (imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      n_err++; $display("FAIL async_reset_bus: addr=%h data=%h, required 00/00000000",
                        imem_addr, imem_wdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    pulse_start();
    send(3'd0, 5'd5, 5'd6, 5'd7, 5'd2, 6'h2A, 16'h0, 26'h0, acc);
    wait_writes(1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wa_q.size() !== 1 || wa_q[0] !== 8'd0 || wd_q[0] !== 32'h00A638AA) begin
      n_err++; $display("FAIL post_reset: writes=%0d addr=%h data=%h, required 1/00/00A638AA",
                        wa_q.size(), wa_q[0], wd_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stream();
    test_illegal();
    test_overflow();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
